axil_timer_irq: RTL and testbench
=================================

Name: axil_timer_irq

Overview:
- AXI-Lite programmable down-counting timer with prescaler, auto-reload/one-shot modes and a sticky interrupt flag.
- Level output irq_o drives one bit of the interrupt controller's irq_inputs_i vector; software clears it write-1-to-clear.
- Provides the periodic tick and timeout interrupts for the SoC firmware.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI-Lite data width; only 32 supported.
- C_S_AXI_ADDR_WIDTH, 32, AXI-Lite address width; only ADDR[4:0] decoded.
- CNT_WIDTH, 32, width of LOAD/COUNT/CMP registers (1..32).
- PRE_WIDTH, 16, width of the PRESCALE register.

Ports:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY: standard AXI-Lite write channels; widths per parameters.
- S_AXI_ARADDR/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI-Lite read channels; widths per parameters.
- irq_o  out  1  level interrupt = PENDING & IRQ_EN.
- pwm_o  out  1  PWM output (see Optional Feature).

Behaviour:
- Reset (async, active-low): all AXI outputs 0, RDATA 0, CTRL 0, PRESCALE 0, LOAD 0, COUNT 0, CMP 0, prescaler counter 0, PENDING 0, irq_o 0, pwm_o 0.
- Register map:
  - 0x00 CTRL: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN.
  - 0x04 PRESCALE.
  - 0x08 LOAD.
  - 0x0C COUNT, read-only.
  - 0x10 STATUS: [0] PENDING, write-1-to-clear.
  - 0x14 CMP, only with the optional feature.
  - Unmapped reads return 0; unmapped writes are ignored. BRESP/RRESP are always 00. WSTRB is ignored (full-word writes).
- Write handshake:
  - The write is accepted in a cycle where AWVALID & WVALID & !AWREADY & !BVALID.
  - Next edge: AWREADY = WREADY = 1 for exactly one cycle and the register update takes effect.
  - BVALID rises the following edge and holds until BREADY; no new write is accepted while BVALID = 1.
- Read handshake:
  - When ARVALID & !ARREADY & !RVALID: ARREADY pulses one cycle and RDATA is captured.
  - RVALID rises the next edge and holds with stable RDATA until RREADY.
  - No new AR is accepted while RVALID = 1.
- Prescaler: while EN = 1, pre_cnt increments each cycle. When pre_cnt == PRESCALE it wraps to 0 and generates tick.
  - The tick rate is therefore clk/(PRESCALE+1); PRESCALE = 0 gives a tick every cycle.
- Counter on tick:
  - If COUNT != 0: COUNT decrements.
  - If COUNT == 0 (expiry): PENDING set. With AUTO_RELOAD = 1, COUNT <= LOAD. With AUTO_RELOAD = 0, EN is cleared by hardware and COUNT stays 0.
- Period: (LOAD+1)*(PRESCALE+1) cycles. LOAD = 0 expires on every tick.
- Writing LOAD: COUNT <= new value and pre_cnt <= 0 in the same edge, whether running or stopped.
- Writing CTRL with EN = 0: COUNT and pre_cnt freeze; re-enabling resumes from the frozen values.
- PENDING set and W1C clear in the same cycle: set wins.
- IRQ_EN = 0 masks irq_o but does not stop PENDING from setting.
- irq_o is registered-free, combinational from flops (PENDING & IRQ_EN). A change is visible the cycle after the causing edge.

Optional Feature:
- Macro TIMER_PWM_EN.
- Defined:
  - CMP register at 0x14 is read/write.
  - pwm_o = EN & (COUNT < CMP), registered, one cycle behind COUNT.
  - CMP = 0 keeps pwm_o low; CMP > LOAD keeps it high while running.
- Undefined:
  - 0x14 reads 0 and writes are ignored.
  - pwm_o tied 0; no CMP flops are synthesised.

Test Plan:
- Reset asserted mid-run (COUNT = 5, PENDING = 1) -> all outputs 0 immediately, without waiting for a clock edge; reads of 0x0C and 0x10 return 0 after reset release.
- PRESCALE = 3, LOAD = 4, CTRL = 0x7 -> first irq_o rise 20 cycles after the CTRL write takes effect, then COUNT reloads to 4. W1C 0x10 = 1 drops irq_o; it re-asserts every 20 cycles.
- One-shot: PRESCALE = 0, LOAD = 2, CTRL = 0x5 -> PENDING after 3 cycles; CTRL reads 0x4 (EN cleared), COUNT stays 0 and irq_o stays 1 until cleared.
- W1C write timed on the expiry cycle -> PENDING remains 1 and irq_o stays high.
- Back-to-back writes with BREADY held low 5 cycles -> second write not accepted (AWREADY stays 0) until BVALID handshake. Read of 0x0C with RREADY low holds RVALID and a stable RDATA.
- With TIMER_PWM_EN: LOAD = 9, CMP = 3, PRESCALE = 0 -> pwm_o high 3 of every 10 cycles. Without the macro, a read of 0x14 returns 0 and pwm_o stays 0.

Source files
------------

// File: rtl/axil_timer_irq.sv
// AXI-Lite down-counting timer with prescaler, one-shot/auto-reload and a sticky W1C interrupt.
// Optional PWM compare output and CMP register enabled by defining TIMER_PWM_EN.
module axil_timer_irq #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH          = 32,
    parameter int unsigned PRE_WIDTH          = 16
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq_o,
    output logic                            pwm_o
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned CW = CNT_WIDTH;
    localparam int unsigned PW = PRE_WIDTH;

    localparam logic [4:0] ADDR_CTRL   = 5'h00;
    localparam logic [4:0] ADDR_PRE    = 5'h04;
    localparam logic [4:0] ADDR_LOAD   = 5'h08;
    localparam logic [4:0] ADDR_COUNT  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;
    localparam logic [4:0] ADDR_CMP    = 5'h14;

    logic          r_awready;
    logic          r_bvalid;
    logic          r_arready;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;

    logic          r_en;
    logic          r_auto;
    logic          r_irq_en;
    logic [PW-1:0] r_prescale;
    logic [PW-1:0] r_pre_cnt;
    logic [CW-1:0] r_load;
    logic [CW-1:0] r_count;
    logic          r_pending;

    logic          w_wr_en;
    logic          w_rd_en;
    logic [4:0]    w_wr_addr;
    logic          w_wr_ctrl;
    logic          w_wr_pre;
    logic          w_wr_load;
    logic          w_wr_status;
    logic          w_wr_cmp;
    logic          w_tick;
    logic          w_expire;
    logic [DW-1:0] w_rd_data;
    logic          w_unused;

    // A write is taken on the edge that raises AWREADY/WREADY; registers update on that same edge.
    assign w_wr_en     = S_AXI_AWVALID & S_AXI_WVALID & ~r_awready & ~r_bvalid;
    assign w_rd_en     = S_AXI_ARVALID & ~r_arready & ~r_rvalid;
    assign w_wr_addr   = S_AXI_AWADDR[4:0];
    assign w_wr_ctrl   = w_wr_en & (w_wr_addr == ADDR_CTRL);
    assign w_wr_pre    = w_wr_en & (w_wr_addr == ADDR_PRE);
    assign w_wr_load   = w_wr_en & (w_wr_addr == ADDR_LOAD);
    assign w_wr_status = w_wr_en & (w_wr_addr == ADDR_STATUS);
    assign w_wr_cmp    = w_wr_en & (w_wr_addr == ADDR_CMP);

    assign w_tick   = r_en & (r_pre_cnt == r_prescale);
    assign w_expire = w_tick & (r_count == '0);

    assign S_AXI_AWREADY = r_awready;
    assign S_AXI_WREADY  = r_awready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = r_arready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;

    assign irq_o = r_pending & r_irq_en;

    // Only the low address bits and low data bits are decoded; strobes are ignored.
    assign w_unused = ^{S_AXI_AWADDR, S_AXI_ARADDR, S_AXI_WSTRB, S_AXI_WDATA};

    // Write channel handshake
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
        end else begin
            r_awready <= w_wr_en;
            if (r_bvalid && S_AXI_BREADY) begin
                r_bvalid <= 1'b0;
            end else if (r_awready) begin
                r_bvalid <= 1'b1;
            end
        end
    end

`ifdef TIMER_PWM_EN
    logic [CW-1:0] r_cmp;
    logic          r_pwm;

    // Compare register and registered PWM output, one cycle behind COUNT
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_cmp <= '0;
            r_pwm <= 1'b0;
        end else begin
            if (w_wr_cmp) begin
                r_cmp <= S_AXI_WDATA[CW-1:0];
            end
            r_pwm <= r_en & (r_count < r_cmp);
        end
    end

    assign pwm_o = r_pwm;
`else
    logic w_unused_cmp;
    assign w_unused_cmp = w_wr_cmp;
    assign pwm_o        = 1'b0;
`endif

    // Read data mux over the register map; unmapped offsets read as zero
    always_comb begin
        w_rd_data = '0;
        case (S_AXI_ARADDR[4:0])
            ADDR_CTRL:   w_rd_data = DW'({r_irq_en, r_auto, r_en});
            ADDR_PRE:    w_rd_data = DW'(r_prescale);
            ADDR_LOAD:   w_rd_data = DW'(r_load);
            ADDR_COUNT:  w_rd_data = DW'(r_count);
            ADDR_STATUS: w_rd_data = DW'(r_pending);
`ifdef TIMER_PWM_EN
            ADDR_CMP:    w_rd_data = DW'(r_cmp);
`endif
            default:     w_rd_data = '0;
        endcase
    end

    // Read channel handshake; RDATA is captured on accept and held while RVALID
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_arready <= w_rd_en;
            if (w_rd_en) begin
                r_rdata <= w_rd_data;
            end
            if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end else if (r_arready) begin
                r_rvalid <= 1'b1;
            end
        end
    end

    // Control and prescale registers; a software CTRL write beats the one-shot EN clear
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_en       <= 1'b0;
            r_auto     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_prescale <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= S_AXI_WDATA[0];
                r_auto   <= S_AXI_WDATA[1];
                r_irq_en <= S_AXI_WDATA[2];
            end else if (w_expire && !r_auto) begin
                r_en <= 1'b0;
            end
            if (w_wr_pre) begin
                r_prescale <= S_AXI_WDATA[PW-1:0];
            end
        end
    end

    // Prescaler and down-counter; a LOAD write restarts both immediately
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_load    <= '0;
            r_count   <= '0;
            r_pre_cnt <= '0;
        end else if (w_wr_load) begin
            r_load    <= S_AXI_WDATA[CW-1:0];
            r_count   <= S_AXI_WDATA[CW-1:0];
            r_pre_cnt <= '0;
        end else begin
            if (r_en) begin
                r_pre_cnt <= w_tick ? '0 : r_pre_cnt + PW'(1);
            end
            if (w_tick) begin
                if (r_count != '0) begin
                    r_count <= r_count - CW'(1);
                end else if (r_auto) begin
                    r_count <= r_load;
                end
            end
        end
    end

    // Sticky pending flag; a same-cycle expiry wins over the W1C clear
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_pending <= 1'b0;
        end else if (w_expire) begin
            r_pending <= 1'b1;
        end else if (w_wr_status && S_AXI_WDATA[0]) begin
            r_pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_timer_irq.sv
// Directed self-checking bench for axil_timer_irq; PWM checks follow TIMER_PWM_EN.
module tb_axil_timer_irq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        irq, pwm;

    int cyc = 0;
    int wr_cyc = 0;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axil_timer_irq dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .irq_o         (irq),
        .pwm_o         (pwm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Write; wr_cyc records the edge on which the register update lands
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
        int n;
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        wr_cyc = cyc;
        check("aw_accept", 32'(awready), 1);
        check("w_ready", 32'(wready), 1);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bvalid && n < 20);
        check("b_valid", 32'(bvalid), 1);
        step(1);
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
        check("ar_accept", 32'(arready), 1);
        arvalid = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!rvalid && n < 20);
        check("r_valid", 32'(rvalid), 1);
        d = rdata;
        step(1);
    endtask

    task automatic wait_irq(input int max, output int at);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < max) begin
            @(posedge clk); #1; n++;
        end
        at = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int c0, c1, c2, c3, t, n, highs;
        awaddr = '0; wdata = '0; wstrb = 4'hF; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset state
        step(3);
        check("rst_awready", 32'(awready), 0);
        check("rst_bvalid", 32'(bvalid), 0);
        check("rst_rvalid", 32'(rvalid), 0);
        check("rst_irq", 32'(irq), 0);
        check("rst_pwm", 32'(pwm), 0);
        rst_n = 1'b1;
        step(1);
        axi_read(32'h00, d); check("rst_ctrl", d, 0);
        axi_read(32'h0C, d); check("rst_count", d, 0);

        // Periodic: PRESCALE=3, LOAD=4 -> 20-cycle period
        axi_write(32'h04, 3);
        axi_write(32'h08, 4);
        axi_write(32'h00, 32'h7); c0 = wr_cyc;
        check("per_irq_low", 32'(irq), 0);
        wait_irq(40, t); check("per_first_rise", t - c0, 20);
        axi_read(32'h0C, d); check("per_reload", d, 4);
        axi_read(32'h10, d); check("per_status", d, 1);
        axi_write(32'h10, 1); check("per_w1c", 32'(irq), 0);
        wait_irq(40, t); check("per_second_rise", t - c0, 40);
        axi_write(32'h10, 1); check("per_w1c2", 32'(irq), 0);
        wait_irq(40, t); check("per_third_rise", t - c0, 60);
        axi_write(32'h00, 0);
        axi_write(32'h10, 1); check("per_stop_clear", 32'(irq), 0);

        // One-shot: PRESCALE=0, LOAD=2 -> pending after 3 cycles, EN cleared
        axi_write(32'h04, 0);
        axi_write(32'h08, 2);
        axi_write(32'h00, 32'h5); c0 = wr_cyc;
        wait_irq(20, t); check("os_rise", t - c0, 3);
        axi_read(32'h00, d); check("os_ctrl", d, 32'h4);
        axi_read(32'h0C, d); check("os_count", d, 0);
        step(10);
        check("os_irq_held", 32'(irq), 1);
        axi_read(32'h0C, d); check("os_count_held", d, 0);
        axi_write(32'h10, 1); check("os_w1c", 32'(irq), 0);

        // W1C landing on the expiry edge: set wins
        axi_write(32'h08, 5);
        axi_write(32'h00, 32'h5); c0 = wr_cyc;
        while (cyc < c0 + 5) step(1);
        axi_write(32'h10, 1);
        check("race_edge", wr_cyc - c0, 6);
        check("race_irq", 32'(irq), 1);
        axi_read(32'h10, d); check("race_status", d, 1);
        axi_write(32'h10, 1);
        axi_read(32'h10, d); check("race_cleared", d, 0);

        // IRQ_EN=0 masks irq_o but PENDING still sets
        axi_write(32'h08, 0);
        axi_write(32'h00, 32'h1);
        step(3);
        check("mask_irq", 32'(irq), 0);
        axi_read(32'h10, d); check("mask_status", d, 1);
        axi_write(32'h00, 32'h4); check("unmask_irq", 32'(irq), 1);
        axi_write(32'h10, 1); check("unmask_w1c", 32'(irq), 0);
        axi_write(32'h00, 0);

        // EN=0 freezes COUNT; re-enable resumes
        axi_write(32'h08, 50);
        axi_write(32'h00, 32'h1); c0 = wr_cyc;
        axi_write(32'h00, 32'h0); c1 = wr_cyc;
        axi_read(32'h0C, d); check("frz_count", d, 32'(50 - (c1 - c0)));
        step(10);
        axi_read(32'h0C, d); check("frz_held", d, 32'(50 - (c1 - c0)));
        axi_write(32'h00, 32'h1); c2 = wr_cyc;
        axi_write(32'h00, 32'h0); c3 = wr_cyc;
        axi_read(32'h0C, d); check("frz_resume", d, 32'(50 - (c1 - c0) - (c3 - c2)));

        // Back-to-back writes with BREADY low
        bready = 1'b0;
        awaddr = 32'h04; wdata = 32'h11; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        check("b2b_first_acc", 32'(awready), 1);
        awaddr = 32'h08; wdata = 32'h7;
        repeat (5) begin
            step(1);
            check("b2b_aw_blocked", 32'(awready), 0);
            check("b2b_bvalid_hold", 32'(bvalid), 1);
        end
        bready = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        check("b2b_second_acc", n, 2);
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!bvalid && n < 20);
        step(1);
        axi_read(32'h04, d); check("b2b_prescale", d, 32'h11);
        axi_read(32'h0C, d); check("b2b_count", d, 7);

        // Read hold: RREADY low keeps RVALID and RDATA stable while COUNT runs
        axi_write(32'h04, 0);
        axi_write(32'h08, 100);
        axi_write(32'h00, 32'h1);
        araddr = 32'h0C; arvalid = 1'b1; rready = 1'b0;
        step(1);
        check("hold_arready", 32'(arready), 1);
        arvalid = 1'b0;
        repeat (5) begin
            step(1);
            check("hold_rvalid", 32'(rvalid), 1);
            check("hold_rdata", rdata, 98);
        end
        rready = 1'b1;
        step(1);
        check("hold_done", 32'(rvalid), 0);
        axi_write(32'h00, 0);

        axi_read(32'h18, d); check("unmapped_rd", d, 0);

        // PWM / CMP
        axi_write(32'h14, 3);
        axi_write(32'h08, 9);
        axi_write(32'h00, 32'h3);
        step(5);
        highs = 0;
        repeat (30) begin
            step(1);
            if (pwm) highs++;
        end
`ifdef TIMER_PWM_EN
        check("pwm_duty", highs, 9);
        axi_read(32'h14, d); check("cmp_rd", d, 3);
`else
        check("pwm_off", highs, 0);
        axi_read(32'h14, d); check("cmp_absent", d, 0);
`endif
        axi_write(32'h00, 0);

        // Reset mid-run with COUNT=5, PENDING=1, BVALID and RVALID outstanding
        axi_write(32'h08, 0);
        axi_write(32'h00, 32'h5);
        axi_write(32'h08, 5);
        check("mid_pre_irq", 32'(irq), 1);
        bready = 1'b0;
        awaddr = 32'h04; wdata = 32'h2; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!awready && n < 20);
        awvalid = 1'b0; wvalid = 1'b0;
        step(1);
        check("mid_pre_bvalid", 32'(bvalid), 1);
        araddr = 32'h08; arvalid = 1'b1; rready = 1'b0;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!arready && n < 20);
        arvalid = 1'b0;
        step(1);
        check("mid_pre_rdata", rdata, 5);
        #2 rst_n = 1'b0;
        #1;
        check("mid_awready", 32'(awready), 0);
        check("mid_bvalid", 32'(bvalid), 0);
        check("mid_arready", 32'(arready), 0);
        check("mid_rvalid", 32'(rvalid), 0);
        check("mid_rdata", rdata, 0);
        check("mid_irq", 32'(irq), 0);
        check("mid_pwm", 32'(pwm), 0);
        step(2);
        #2 rst_n = 1'b1;
        step(1);
        axi_read(32'h0C, d); check("post_count", d, 0);
        axi_read(32'h10, d); check("post_status", d, 0);
        axi_read(32'h00, d); check("post_ctrl", d, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
